// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage resolver for conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU).
// It turns the comparator flags into a taken/not-taken decision and computes
// the next PC. The result is checked against the fetch-time prediction. On a
// mispredict it issues a registered redirect and holds a front-end flush for
// FLUSH_CYCLES cycles. It also owns the 2-bit saturating BHT that fetch reads
// and resolution trains.
//
// Ports
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_valid               branch in execute, comparator flags valid
//   i_funct3              branch funct3
//   i_gt, i_lt, i_eq      comparator results
//   o_sign                comparator signedness select (combinational)
//   i_pc, i_imm           branch PC and sign-extended B-immediate
//   i_pred_taken          prediction used at fetch
//   i_lookup_pc           fetch lookup PC for the BHT read port
//   o_predict             BHT prediction for i_lookup_pc (combinational)
//   o_redirect            one-cycle redirect pulse (registered)
//   o_redirect_pc         redirect target, valid while o_redirect is high
//   o_flush               front-end kill (registered)
//   o_misalign            one-cycle pulse: taken target not 4-byte aligned
//   o_illegal             one-cycle pulse: reserved funct3 (010/011)
//   o_branch_cnt          count of accepted legal branches
//   o_mispred_cnt         count of accepted mispredicts that redirected
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int unsigned BHT_ENTRIES  = 16,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [2:0]  i_funct3,
   input  logic        i_gt,
   input  logic        i_lt,
   input  logic        i_eq,
   output logic        o_sign,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_imm,
   input  logic        i_pred_taken,
   input  logic [31:0] i_lookup_pc,
   output logic        o_predict,
   output logic        o_redirect,
   output logic [31:0] o_redirect_pc,
   output logic        o_flush,
   output logic        o_misalign,
   output logic        o_illegal,
   output logic [31:0] o_branch_cnt,
   output logic [31:0] o_mispred_cnt
);

   localparam int unsigned IDX   = $clog2(BHT_ENTRIES);
   // Keep the flush counter at least one bit wide so FLUSH_CYCLES=1 still works.
   localparam int unsigned CTR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {
      StIdle,
      StFlush
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e             state_q, state_d;
   logic [CTR_W-1:0]   flush_ctr_q, flush_ctr_d;
   logic [1:0]         bht_q [BHT_ENTRIES];
   logic [1:0]         bht_d [BHT_ENTRIES];
   logic               redirect_q, redirect_d;
   logic [31:0]        redirect_pc_q, redirect_pc_d;
   logic               flush_q, flush_d;
   logic               misalign_q, misalign_d;
   logic               illegal_q, illegal_d;
   logic [31:0]        branch_cnt_q, branch_cnt_d;
   logic [31:0]        mispred_cnt_q, mispred_cnt_d;

   // ---------------------------------------------------------------------------
   // Resolution datapath
   // ---------------------------------------------------------------------------
   logic           accept;
   logic           is_illegal;
   logic           taken;
   logic [31:0]    target;
   logic           target_misalign;
   logic           mispredict;
   logic           do_branch;
   logic           do_redirect;
   logic [IDX-1:0] upd_idx;
   logic [IDX-1:0] lookup_idx;
   logic           unused_lookup_bits;

   // Funct3[1] distinguishes the unsigned compares (BLTU/BGEU).
   assign o_sign = ~i_funct3[1];

   assign upd_idx    = i_pc[IDX+1:2];
   assign lookup_idx = i_lookup_pc[IDX+1:2];
   // Read before any same-cycle write lands, so a colliding lookup sees the old value.
   assign o_predict  = bht_q[lookup_idx][1];

   assign unused_lookup_bits = ^{i_lookup_pc[31:IDX+2], i_lookup_pc[1:0]};

   // Branches arriving while the front end is being flushed are wrong-path.
   assign accept     = i_valid && (state_q == StIdle);
   assign is_illegal = (i_funct3[2:1] == 2'b01);

   always_comb begin
      taken = 1'b0;
      case (i_funct3)
         3'b000:         taken = i_eq;
         3'b001:         taken = ~i_eq;
         3'b100, 3'b110: taken = i_lt;
         3'b101, 3'b111: taken = i_gt | i_eq;
         default:        taken = 1'b0;
      endcase
   end

   assign target          = taken ? (i_pc + i_imm) : (i_pc + 32'd4);
   assign target_misalign = taken & target[1];
   assign mispredict      = (taken != i_pred_taken);
   assign do_branch       = accept & ~is_illegal;
   // A misaligned target traps elsewhere; it never redirects or flushes here.
   assign do_redirect     = do_branch & mispredict & ~target_misalign;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= StIdle;
         flush_ctr_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_ctr_q <= flush_ctr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      flush_ctr_d = flush_ctr_q;
      unique case (state_q)
         StIdle: begin
            if (do_redirect) begin
               state_d     = StFlush;
               flush_ctr_d = CTR_W'(FLUSH_CYCLES - 1);
            end
         end
         StFlush: begin
            if (flush_ctr_q == '0) begin
               state_d = StIdle;
            end else begin
               flush_ctr_d = flush_ctr_q - CTR_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (next values of the registered outputs)
   // ---------------------------------------------------------------------------
   always_comb begin
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      flush_d       = 1'b0;
      misalign_d    = 1'b0;
      illegal_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            redirect_d = do_redirect;
            flush_d    = do_redirect;
            misalign_d = do_branch & target_misalign;
            illegal_d  = accept & is_illegal;
            if (do_redirect) begin
               redirect_pc_d = target;
            end
         end
         StFlush: begin
            // Stay high until the counter expires on this edge.
            flush_d = (flush_ctr_q != '0);
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // BHT training and event counters
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
         bht_d[i] = bht_q[i];
      end
      if (do_branch) begin
         if (taken) begin
            if (bht_q[upd_idx] != 2'b11) begin
               bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
            end
         end else begin
            if (bht_q[upd_idx] != 2'b00) begin
               bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
            end
         end
      end
   end

   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (do_branch) begin
         branch_cnt_d = branch_cnt_q + 32'd1;
      end
      if (do_redirect) begin
         mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
            bht_q[i] <= 2'b01;
         end
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         flush_q       <= 1'b0;
         misalign_q    <= 1'b0;
         illegal_q     <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
            bht_q[i] <= bht_d[i];
         end
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         flush_q       <= flush_d;
         misalign_q    <= misalign_d;
         illegal_q     <= illegal_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign o_redirect    = redirect_q;
   assign o_redirect_pc = redirect_pc_q;
   assign o_flush       = flush_q;
   assign o_misalign    = misalign_q;
   assign o_illegal     = illegal_q;
   assign o_branch_cnt  = branch_cnt_q;
   assign o_mispred_cnt = mispred_cnt_q;

endmodule
